// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-side blocks: data width default,
// memory responder FSM states and operation-type encodings.
package cpu_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } mem_state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM, word addressed, with a registered read port.
module ram_array #(
    parameter int wordSize = 32,
    parameter int addrBits = 9
) (
    input  logic                clk,
    input  logic                we,
    input  logic [addrBits-1:0] addr,
    input  logic [wordSize-1:0] din,
    output logic [wordSize-1:0] dout
);

    logic [wordSize-1:0] mem [2**addrBits];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: latches one request,
// stalls for waitStates cycles, accesses the RAM and pulses done.
//
//  state  | meaning
//  IDLE   | waiting for exactly one of read/write; both high is rejected (err)
//  WAIT   | counting down inserted wait states
//  ACCESS | RAM write performed / RAM read registered at the end of this cycle
//  DONE   | read data moved to Mdatain, done raised for one cycle
module mem_responder
    import cpu_pkg::*;
#(
    parameter int wordSize   = WORD_SIZE,
    parameter int addrBits   = 9,
    parameter int waitStates = 2
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                read,
    input  logic                write,
    input  logic [addrBits-1:0] addr,
    input  logic [wordSize-1:0] wdata,
    output logic [wordSize-1:0] Mdatain,
    output logic                done,
    output logic                busy,
    output logic                err
);

    localparam logic [3:0] WS = 4'(waitStates);

    mem_state_t          state;
    logic [3:0]          cnt;
    logic                op_q;
    logic [addrBits-1:0] addr_q;
    logic [wordSize-1:0] wdata_q;
    logic [wordSize-1:0] ram_dout;
    logic                ram_we;

    // Gated by clr so a reset landing on ACCESS suppresses the write.
    assign ram_we = clr && (state == ACCESS) && (op_q == OP_WR);

    ram_array #(
        .wordSize (wordSize),
        .addrBits (addrBits)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr_q),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            Mdatain <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (read ^ write) begin
                        busy    <= 1'b1;
                        op_q    <= write ? OP_WR : OP_RD;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= WS;
                        state   <= (WS == 4'd0) ? ACCESS : WAIT;
                    end else if (read && write) begin
                        err <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                end
                DONE: begin
                    // busy stays high through the done cycle; IDLE drops it.
                    if (op_q == OP_RD) begin
                        Mdatain <= ram_dout;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with 0.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        rd   [2];
    logic        wr   [2];
    logic [8:0]  ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] mdat [2];
    logic        dn   [2];
    logic        bz   [2];
    logic        er   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.wordSize(32), .addrBits(9), .waitStates(2)) u_ws2 (
        .clk(clk), .clr(clr), .read(rd[0]), .write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
        .Mdatain(mdat[0]), .done(dn[0]), .busy(bz[0]), .err(er[0])
    );

    mem_responder #(.wordSize(32), .addrBits(9), .waitStates(0)) u_ws0 (
        .clk(clk), .clr(clr), .read(rd[1]), .write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
        .Mdatain(mdat[1]), .done(dn[1]), .busy(bz[1]), .err(er[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Presents a request across one rising edge (the accept edge E), returns at E+1ns.
    task automatic start_req(input int u, input logic r, input logic w,
                             input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        rd[u] = r; wr[u] = w; ad[u] = a; wd[u] = d;
        @(posedge clk);
        #1;
        rd[u] = 1'b0; wr[u] = 1'b0;
    endtask

    // k0 = edges already elapsed since E; expd is the expected Mdatain at done.
    task automatic wait_done(input int u, input string tag, input int k0, input int explat,
                             input logic [31:0] expd);
        int lat = -1;
        for (int k = k0 + 1; k <= k0 + 40; k++) begin
            @(posedge clk);
            #1;
            if (dn[u]) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, explat);
        if (lat >= 0) begin
            chk({tag, "_busy"}, {31'd0, bz[u]}, 32'd1);
            chk({tag, "_data"}, mdat[u], expd);
        end
    endtask

    task automatic req(input int u, input string tag, input logic r, input logic w,
                       input logic [8:0] a, input logic [31:0] d, input int explat,
                       input logic [31:0] expd);
        start_req(u, r, w, a, d);
        wait_done(u, tag, 0, explat, expd);
    endtask

    initial begin
        int cnt_hi;
        for (int u = 0; u < 2; u++) begin
            rd[u] = 1'b0; wr[u] = 1'b0; ad[u] = '0; wd[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mdat", mdat[0], 32'h0);
        chk("rst_done", {31'd0, dn[0]}, 32'd0);
        chk("rst_busy", {31'd0, bz[0]}, 32'd0);
        chk("rst_err",  {31'd0, er[0]}, 32'd0);
        chk("rst_busy_b", {31'd0, bz[1]}, 32'd0);
        @(negedge clk);
        clr = 1'b1;

        // Write then read back; writes leave Mdatain untouched.
        req(0, "wr5", 1'b0, 1'b1, 9'd5, 32'hDEADBEEF, 4, 32'h0);
        @(posedge clk);
        #1;
        chk("post_done_busy", {31'd0, bz[0]}, 32'd0);
        chk("post_done_done", {31'd0, dn[0]}, 32'd0);
        req(0, "rd5", 1'b1, 1'b0, 9'd5, 32'h0, 4, 32'hDEADBEEF);

        // Back-to-back at the maximum rate, including the top address.
        req(0, "wr0",   1'b0, 1'b1, 9'd0,   32'h1, 4, 32'hDEADBEEF);
        req(0, "wr511", 1'b0, 1'b1, 9'd511, 32'h2, 4, 32'hDEADBEEF);
        req(0, "rd0",   1'b1, 1'b0, 9'd0,   32'h0, 4, 32'h1);
        req(0, "rd511", 1'b1, 1'b0, 9'd511, 32'h0, 4, 32'h2);

        // Conflicting request is rejected.
        start_req(0, 1'b1, 1'b1, 9'd5, 32'h12345678);
        chk("conf_err",  {31'd0, er[0]}, 32'd1);
        chk("conf_busy", {31'd0, bz[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("conf_err_pulse", {31'd0, er[0]}, 32'd0);
        cnt_hi = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (dn[0] || bz[0]) cnt_hi++;
        end
        chk("conf_no_done", cnt_hi, 0);
        req(0, "conf_rd5", 1'b1, 1'b0, 9'd5, 32'h0, 4, 32'hDEADBEEF);

        // Write issued while a read is in WAIT is dropped.
        req(0, "wr7", 1'b0, 1'b1, 9'd7, 32'h77, 4, 32'hDEADBEEF);
        start_req(0, 1'b1, 1'b0, 9'd5, 32'h0);
        start_req(0, 1'b0, 1'b1, 9'd7, 32'hBAD);
        wait_done(0, "busy_rd5", 1, 4, 32'hDEADBEEF);
        req(0, "rd7", 1'b1, 1'b0, 9'd7, 32'h0, 4, 32'h77);

        // Reset while a write is in WAIT.
        req(0, "wr3", 1'b0, 1'b1, 9'd3, 32'h33, 4, 32'h77);
        start_req(0, 1'b0, 1'b1, 9'd3, 32'hFFFF);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_mdat", mdat[0], 32'h0);
        chk("mrst_done", {31'd0, dn[0]}, 32'd0);
        chk("mrst_busy", {31'd0, bz[0]}, 32'd0);
        chk("mrst_err",  {31'd0, er[0]}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        cnt_hi = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (dn[0]) cnt_hi++;
        end
        chk("mrst_no_done", cnt_hi, 0);
        req(0, "rd3", 1'b1, 1'b0, 9'd3, 32'h0, 4, 32'h33);

        // Reset landing on the ACCESS cycle suppresses the write.
        req(0, "wr4", 1'b0, 1'b1, 9'd4, 32'h44, 4, 32'h33);
        start_req(0, 1'b0, 1'b1, 9'd4, 32'h999);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_busy", {31'd0, bz[0]}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        req(0, "rd4", 1'b1, 1'b0, 9'd4, 32'h0, 4, 32'h44);

        // Zero wait states: done at E+2, write then immediate read.
        req(1, "b_wr9", 1'b0, 1'b1, 9'd9, 32'hA5A5A5A5, 2, 32'h0);
        req(1, "b_rd9", 1'b1, 1'b0, 9'd9, 32'h0,        2, 32'hA5A5A5A5);
        req(1, "b_wr9b", 1'b0, 1'b1, 9'd9, 32'h0000005A, 2, 32'hA5A5A5A5);
        req(1, "b_rd9b", 1'b1, 1'b0, 9'd9, 32'h0,        2, 32'h0000005A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
